// File: rtl/fpdiv_sched.sv
// fpdiv_sched -- two-requester scheduler in front of one shared multi-cycle
// FP32 divider.
//
// A round-robin arbiter grants one requester while IDLE. The granted
// operands are registered onto div_a/div_b. They are held there until the
// next grant. After DIV_LAT cycles the quotient is captured from div_c and
// presented on the response port until it is accepted.
//
// Parameters
//   DIV_LAT     cycles the divider needs with stable operands (2..15)
//
// Ports
//   clk                     rising-edge clock
//   rst                     asynchronous reset, active low
//   req{0,1}_valid          requester has an operation pending
//   req{0,1}_a / _b         FP32 dividend / divisor
//   req{0,1}_ready          operation accepted this cycle (combinational)
//   div_a, div_b            operands to the shared divider
//   div_c                   divider quotient
//   resp_valid/_id/_data    response, held until resp_ready
//   resp_ready              response consumer ready
//   busy                    scheduler not idle
//
// Optional feature (macro FPDIV_SCHED_SPECIAL_EN)
//   A zero-exponent divisor returns a signed infinity. A zero-exponent
//   dividend returns a signed zero. Either result is produced straight at
//   the grant, so the response follows one cycle later. The divider and
//   its operands are not touched.
module fpdiv_sched #(
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_c,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_data,
  input  logic        resp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The counter runs DIV_LAT-1 down to 0. That gives DIV_LAT WAIT cycles,
  // and the operands are stable on the divider for all of them.
  localparam logic [3:0] LP_CNT_INIT = 4'(DIV_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_last;
  logic [31:0] r_div_a, r_div_b, r_resp_data;
  logic        r_resp_id;

  logic        w_any, w_gnt, w_hs, w_byp;
  logic [31:0] w_a, w_b, w_byp_data;

  // Sole requester wins. On a tie, the one not granted last time wins.
  assign w_any = req0_valid | req1_valid;
  assign w_gnt = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_hs  = (r_state == S_IDLE) & w_any;
  assign w_a   = w_gnt ? req1_a : req0_a;
  assign w_b   = w_gnt ? req1_b : req0_b;

`ifdef FPDIV_SCHED_SPECIAL_EN
  // The divisor check comes first, so 0/0 gives an infinity.
  assign w_byp      = (w_b[30:23] == 8'd0) | (w_a[30:23] == 8'd0);
  assign w_byp_data = (w_b[30:23] == 8'd0) ? {w_a[31] ^ w_b[31], 31'h7F800000}
                                           : {w_a[31] ^ w_b[31], 31'h0};
`else
  assign w_byp      = 1'b0;
  assign w_byp_data = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_hs)           w_state_nxt = w_byp ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0)  w_state_nxt = S_RESP;
      S_RESP: if (resp_ready)     w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 4'd0;
      r_last      <= 1'b1;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_resp_data <= '0;
      r_resp_id   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_resp_id <= w_gnt;
            r_last    <= w_gnt;
            if (w_byp) begin
              r_resp_data <= w_byp_data;
            end else begin
              r_div_a <= w_a;
              r_div_b <= w_b;
              r_cnt   <= LP_CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_resp_data <= div_c;
          else               r_cnt       <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_hs & ~w_gnt;
  assign req1_ready = w_hs &  w_gnt;
  assign div_a      = r_div_a;
  assign div_b      = r_div_b;
  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = (r_state != S_IDLE);

endmodule
